data_memory: RTL and testbench

- Responder end of the CPU data-memory interface: receives the CPU's data address, read/write select and write data, and returns read data.
- Contains a word-addressed RAM plus a small memory-mapped I/O window: an output register, a free-running cycle counter and a write counter.
- Sits beside the CPU in the top-level system; the instruction side is served by a separate block.
- Read data is registered (1-cycle latency); writes commit on the clock edge.

---
 rtl/data_memory.sv | 117 +++++++++++
 tb/tb_data_memory.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// data_memory: CPU data-side responder. Word-addressed RAM with a 16-word MMIO window
// holding an output register, a free-running cycle counter and a committed-write counter.
// Read data is registered (one cycle latency); writes commit on the clock edge.
module data_memory #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [15:0] MMIO_BASE = 16'hFFF0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic [31:0] o_mmio_out,
  output logic        o_fault
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Source of the registered read data for the current cycle
  localparam logic [1:0] SrcZero = 2'd0;
  localparam logic [1:0] SrcRam  = 2'd1;
  localparam logic [1:0] SrcReg  = 2'd2;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_rdata_q;

  logic [1:0]  src_q, src_d;
  logic [31:0] reg_rdata_q, reg_rdata_d;
  logic [31:0] mmio_out_q, mmio_out_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] writes_q, writes_d;
  logic        fault_q, fault_d;

  logic [15:0] mmio_off;
  logic        is_mmio;
  logic        is_ram;
  logic        ram_wr;
  logic        out_wr;
  logic        ram_we;

  // Address decode: MMIO window takes priority over RAM, everything else is unmapped
  always_comb begin
    mmio_off = i_address - MMIO_BASE;
    is_mmio  = (i_address >= MMIO_BASE) && (mmio_off < 16'd16);
    is_ram   = !is_mmio && ({16'd0, i_address} < DEPTH);
    ram_wr   = is_ram && !i_rw;
    out_wr   = is_mmio && (mmio_off[3:0] == 4'd0) && !i_rw;
    // Reset winning the edge must block the RAM commit, since the array itself has no reset
    ram_we   = ram_wr && !i_reset;
  end

  // Single-port synchronous RAM, read-before-write on the same index
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      mem[i_address[AW-1:0]] <= i_data;
    end
    ram_rdata_q <= mem[i_address[AW-1:0]];
  end

  // MMIO read mux and next-state for counters, output register and fault pulse
  always_comb begin
    reg_rdata_d = 32'd0;
    unique case (mmio_off[3:0])
      4'd0:    reg_rdata_d = mmio_out_q;
      4'd1:    reg_rdata_d = cycles_q;
      4'd2:    reg_rdata_d = writes_q;
      default: reg_rdata_d = 32'd0;
    endcase

    if (is_ram) begin
      src_d = SrcRam;
    end else if (is_mmio) begin
      src_d = SrcReg;
    end else begin
      src_d = SrcZero;
    end

    mmio_out_d = out_wr ? i_data : mmio_out_q;
    cycles_d   = cycles_q + 32'd1;
    writes_d   = (ram_wr || out_wr) ? writes_q + 32'd1 : writes_q;
    fault_d    = !is_mmio && !is_ram;
  end

  // Control and MMIO state, cleared asynchronously
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      src_q       <= SrcZero;
      reg_rdata_q <= 32'd0;
      mmio_out_q  <= 32'd0;
      cycles_q    <= 32'd0;
      writes_q    <= 32'd0;
      fault_q     <= 1'b0;
    end else begin
      src_q       <= src_d;
      reg_rdata_q <= reg_rdata_d;
      mmio_out_q  <= mmio_out_d;
      cycles_q    <= cycles_d;
      writes_q    <= writes_d;
      fault_q     <= fault_d;
    end
  end

  // Output select uses only registered state, so no address-to-data combinational path
  always_comb begin
    o_data = 32'd0;
    case (src_q)
      SrcRam:  o_data = ram_rdata_q;
      SrcReg:  o_data = reg_rdata_q;
      default: o_data = 32'd0;
    endcase
  end

  assign o_mmio_out = mmio_out_q;
  assign o_fault    = fault_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: table of access vectors plus hand sequences for counter wrap
// and reset landing in the middle of a write.
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [15:0] address;
  logic        rw;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] mmio;
  logic        fault;

  int n_checks;
  int n_pass;

  data_memory #(
    .DEPTH    (1024),
    .MMIO_BASE(16'hFFF0)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_address (address),
    .i_rw      (rw),
    .i_data    (wdata),
    .o_data    (rdata),
    .o_mmio_out(mmio),
    .o_fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_d;
    logic [31:0] d;
    bit          f;
    logic [31:0] m;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    bit          r;
    logic [31:0] wd;
    bit          chk_d;
    logic [31:0] d;
    bit          f;
    logic [31:0] m;
  } vec_t;

  exp_t sb[$];
  vec_t vt[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk_d) check({e.name, ".data"}, rdata, e.d);
      check({e.name, ".fault"}, {31'd0, fault}, {31'd0, e.f});
      check({e.name, ".mmio"}, mmio, e.m);
    end
  endtask

  // Drive one access, queue its expectation, then compare after the sampling edge
  task automatic access(input string name, input logic [15:0] a, input bit r,
                        input logic [31:0] wd, input bit chk, input logic [31:0] d,
                        input bit f, input logic [31:0] m);
    exp_t e;
    address = a;
    rw      = r;
    wdata   = wd;
    e.name  = name;
    e.chk_d = chk;
    e.d     = d;
    e.f     = f;
    e.m     = m;
    sb.push_back(e);
    tick();
    drain();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    //           addr      rw  wdata          chk data           flt mmio
    vt[0]  = '{16'h0005, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h0};
    vt[1]  = '{16'h0005, 1'b1, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[2]  = '{16'h0005, 1'b0, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[3]  = '{16'h0005, 1'b1, 32'h0,        1'b1, 32'h12345678, 1'b0, 32'h0};
    vt[4]  = '{16'h0000, 1'b0, 32'h11111111, 1'b0, 32'h0,        1'b0, 32'h0};
    vt[5]  = '{16'hFFF0, 1'b0, 32'h000000A5, 1'b1, 32'h0,        1'b0, 32'hA5};
    vt[6]  = '{16'hFFF0, 1'b1, 32'h0,        1'b1, 32'hA5,       1'b0, 32'hA5};
    vt[7]  = '{16'hFFF2, 1'b1, 32'h0,        1'b1, 32'd4,        1'b0, 32'hA5};
    vt[8]  = '{16'hFFF1, 1'b0, 32'h0000DEAD, 1'b0, 32'h0,        1'b0, 32'hA5};
    vt[9]  = '{16'hFFF2, 1'b1, 32'h0,        1'b1, 32'd4,        1'b0, 32'hA5};
    vt[10] = '{16'hFFF5, 1'b0, 32'h00000777, 1'b1, 32'h0,        1'b0, 32'hA5};
    vt[11] = '{16'hFFF5, 1'b1, 32'h0,        1'b1, 32'h0,        1'b0, 32'hA5};
    vt[12] = '{16'h8000, 1'b1, 32'h0,        1'b1, 32'h0,        1'b1, 32'hA5};
    vt[13] = '{16'h0000, 1'b1, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'hA5};
    vt[14] = '{16'h8000, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 32'hA5};
    vt[15] = '{16'h0000, 1'b1, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'hA5};
    vt[16] = '{16'hFFF2, 1'b1, 32'h0,        1'b1, 32'd4,        1'b0, 32'hA5};
    vt[17] = '{16'h0400, 1'b1, 32'h0,        1'b1, 32'h0,        1'b1, 32'hA5};
    vt[18] = '{16'h03FF, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 32'hA5};
    vt[19] = '{16'h03FF, 1'b1, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 32'hA5};
    vt[20] = '{16'hFFF2, 1'b1, 32'h0,        1'b1, 32'd5,        1'b0, 32'hA5};

    // Reset state, checked both immediately and while held across edges
    reset   = 1'b1;
    address = 16'h0000;
    rw      = 1'b1;
    wdata   = 32'h0;
    #1;
    check("rst0.data", rdata, 32'h0);
    check("rst0.mmio", mmio, 32'h0);
    check("rst0.fault", {31'd0, fault}, 32'h0);
    tick();
    tick();
    check("rst1.data", rdata, 32'h0);
    check("rst1.mmio", mmio, 32'h0);
    check("rst1.fault", {31'd0, fault}, 32'h0);
    reset = 1'b0;

    // Cycle counter starts at zero on the first edge out of reset
    access("cyc_first", 16'hFFF1, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
    access("cyc_second", 16'hFFF1, 1'b1, 32'h0, 1'b1, 32'h1, 1'b0, 32'h0);

    for (int i = 0; i < 21; i++) begin
      access($sformatf("vec%0d", i), vt[i].a, vt[i].r, vt[i].wd, vt[i].chk_d, vt[i].d,
             vt[i].f, vt[i].m);
    end

    // 2 + 21 edges have elapsed since release
    access("cyc_after_table", 16'hFFF1, 1'b1, 32'h0, 1'b1, 32'd23, 1'b0, 32'hA5);

    // Counter wrap via hierarchical deposit between edges
    dut.cycles_q = 32'hFFFFFFFE;
    access("wrap0", 16'hFFF1, 1'b1, 32'h0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'hA5);
    access("wrap1", 16'hFFF1, 1'b1, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'hA5);
    access("wrap2", 16'hFFF1, 1'b1, 32'h0, 1'b1, 32'h00000000, 1'b0, 32'hA5);
    access("writes_post_wrap", 16'hFFF2, 1'b1, 32'h0, 1'b1, 32'd5, 1'b0, 32'hA5);

    // Reset lands between edges while a write to OUT is being presented
    address = 16'hFFF0;
    rw      = 1'b0;
    wdata   = 32'h00000055;
    #2;
    reset = 1'b1;
    #1;
    check("midrst.mmio_async", mmio, 32'h0);
    check("midrst.data_async", rdata, 32'h0);
    check("midrst.fault_async", {31'd0, fault}, 32'h0);
    tick();
    check("midrst.mmio_held", mmio, 32'h0);
    reset = 1'b0;
    access("midrst.out_read", 16'hFFF0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
    access("midrst.ram5", 16'h0005, 1'b1, 32'h0, 1'b1, 32'h12345678, 1'b0, 32'h0);
    access("midrst.ram3ff", 16'h03FF, 1'b1, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0);
    access("midrst.writes", 16'hFFF2, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0);
    access("midrst.cycles", 16'hFFF1, 1'b1, 32'h0, 1'b1, 32'd4, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
